// File: rtl/snake_ctrl_if.sv
`timescale 1ns/1ps
// Signal bundle between the snake game controller (master) and the
// button/datapath side (slave).
interface snake_ctrl_if #(
   parameter int X_BITS  = 6,
   parameter int Y_BITS  = 5,
   parameter int SCORE_W = 8
);
   logic               btn_up;
   logic               btn_dn;
   logic               btn_lt;
   logic               btn_rt;
   logic               btn_start;
   logic               self_hit;
   logic               ate;
   logic               step;
   logic               grow;
   logic [1:0]         dir;
   logic [X_BITS-1:0]  head_x;
   logic [Y_BITS-1:0]  head_y;
   logic [X_BITS-1:0]  next_x;
   logic [Y_BITS-1:0]  next_y;
   logic [1:0]         state;
   logic [SCORE_W-1:0] score;
   logic [3:0]         level;

   modport master (
      input  btn_up, btn_dn, btn_lt, btn_rt, btn_start, self_hit, ate,
      output step, grow, dir, head_x, head_y, next_x, next_y, state, score, level
   );

   modport slave (
      output btn_up, btn_dn, btn_lt, btn_rt, btn_start, self_hit, ate,
      input  step, grow, dir, head_x, head_y, next_x, next_y, state, score, level
   );
endinterface

// File: rtl/snake_ctrl.sv
`timescale 1ns/1ps
// Snake game controller: FSM, head position, turn queue, move timer, score.
// Define SNAKE_CTRL_PAUSE_EN to let the start button pause a running game.
module snake_ctrl #(
   parameter int X_BITS           = 6,
   parameter int Y_BITS           = 5,
   parameter int GRID_W           = 40,
   parameter int GRID_H           = 30,
   parameter int BASE_PERIOD      = 4_166_666,
   parameter int MIN_PERIOD       = 1_250_000,
   parameter int PERIOD_STEP      = 250_000,
   parameter int APPLES_PER_LEVEL = 4,
   parameter int TURN_DEPTH       = 2,
   parameter int WRAP             = 1,
   parameter int SCORE_W          = 8
) (
   input logic          clk,
   input logic          reset_n,
   snake_ctrl_if.master bus
);
   localparam int PW = $clog2(BASE_PERIOD + 1);
   localparam int QW = $clog2(TURN_DEPTH + 1);
   localparam int AW = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;
   localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
   localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);
   localparam logic [X_BITS-1:0] X_MID = X_BITS'(GRID_W / 2);
   localparam logic [Y_BITS-1:0] Y_MID = Y_BITS'(GRID_H / 2);

   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, OVER = 2'b11} state_t;

   state_t             state_q;
   logic [X_BITS-1:0]  head_x, next_x;
   logic [Y_BITS-1:0]  head_y, next_y;
   logic [1:0]         dir_q, dir_eff, tail, ref_dir, cand;
   logic [SCORE_W-1:0] score_q;
   logic [3:0]         level_q;
   logic [AW-1:0]      apple_cnt;
   logic [PW-1:0]      timer, period;
   logic [31:0]        dec;
   logic [1:0]         q [TURN_DEPTH];
   logic [1:0]         q_nxt [TURN_DEPTH];
   logic [QW-1:0]      q_cnt, q_cnt_nxt;
   logic [4:0]         btn_raw, sync1, sync2, btn_prev, edges;
   logic               start_edge, cand_v, accept, pop, clear;
   logic               due, wall_hit, hit, step;

   assign btn_raw    = {bus.btn_up, bus.btn_dn, bus.btn_lt, bus.btn_rt, bus.btn_start};
   assign edges      = sync2 & ~btn_prev;
   assign start_edge = edges[0];

   // Move period shrinks with level, clamped at the floor (also guards underflow).
   always_comb begin
      dec = 32'(level_q) * 32'(PERIOD_STEP);
      if (dec >= 32'(BASE_PERIOD - MIN_PERIOD)) period = PW'(MIN_PERIOD);
      else                                      period = PW'(32'(BASE_PERIOD) - dec);
   end

   assign due  = (state_q == RUN) && (timer == period - PW'(1));
   assign hit  = bus.self_hit | wall_hit;
   assign step = due & ~hit;

   always_comb begin
      tail = dir_q;
      for (int i = 0; i < TURN_DEPTH; i++)
         if (q_cnt == QW'(i + 1)) tail = q[i];
   end

   assign dir_eff = (q_cnt != '0) ? q[0] : dir_q;
   assign ref_dir = (q_cnt != '0) ? tail : dir_q;

   // One direction candidate per cycle; a repeat or a reversal is rejected.
   always_comb begin
      cand   = 2'b00;
      cand_v = 1'b0;
      if (edges[4])      begin cand = 2'b00; cand_v = 1'b1; end
      else if (edges[3]) begin cand = 2'b10; cand_v = 1'b1; end
      else if (edges[2]) begin cand = 2'b11; cand_v = 1'b1; end
      else if (edges[1]) begin cand = 2'b01; cand_v = 1'b1; end
      accept = cand_v && (state_q == IDLE || state_q == RUN) &&
               (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));
   end

   assign pop   = step && (q_cnt != '0);
   assign clear = (state_q == OVER) && start_edge;

   // Pop before push so a full queue can still accept a turn in a move cycle.
   always_comb begin
      q_nxt     = q;
      q_cnt_nxt = q_cnt;
      if (pop) begin
         for (int i = 0; i < TURN_DEPTH - 1; i++) q_nxt[i] = q[i + 1];
         q_cnt_nxt = q_cnt - QW'(1);
      end
      if (accept && (q_cnt_nxt < QW'(TURN_DEPTH))) begin
         for (int i = 0; i < TURN_DEPTH; i++)
            if (q_cnt_nxt == QW'(i)) q_nxt[i] = cand;
         q_cnt_nxt = q_cnt_nxt + QW'(1);
      end
      if (clear) q_cnt_nxt = '0;
   end

   always_comb begin
      next_x   = head_x;
      next_y   = head_y;
      wall_hit = 1'b0;
      case (dir_eff)
         2'b00: if (head_y == '0)   begin next_y = Y_MAX; wall_hit = (WRAP == 0); end
                else next_y = head_y - Y_BITS'(1);
         2'b01: if (head_x == X_MAX) begin next_x = '0;   wall_hit = (WRAP == 0); end
                else next_x = head_x + X_BITS'(1);
         2'b10: if (head_y == Y_MAX) begin next_y = '0;   wall_hit = (WRAP == 0); end
                else next_y = head_y + Y_BITS'(1);
         default: if (head_x == '0) begin next_x = X_MAX; wall_hit = (WRAP == 0); end
                  else next_x = head_x - X_BITS'(1);
      endcase
   end

   // Game FSM; in a RUN move cycle death/step is resolved before any pause request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1     <= '0;
         sync2     <= '0;
         btn_prev  <= '0;
         state_q   <= IDLE;
         head_x    <= X_MID;
         head_y    <= Y_MID;
         dir_q     <= 2'b01;
         score_q   <= '0;
         level_q   <= '0;
         apple_cnt <= '0;
         timer     <= '0;
         q         <= '{default: 2'b00};
         q_cnt     <= '0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         btn_prev <= sync2;
         q        <= q_nxt;
         q_cnt    <= q_cnt_nxt;
         case (state_q)
            IDLE: if (start_edge) begin
               state_q <= RUN;
               timer   <= '0;
            end
            RUN: begin
`ifdef SNAKE_CTRL_PAUSE_EN
               if (start_edge) state_q <= PAUSE;
`endif
               if (due) begin
                  timer <= '0;
                  if (hit) state_q <= OVER;
                  else begin
                     head_x <= next_x;
                     head_y <= next_y;
                     dir_q  <= dir_eff;
                     if (bus.ate) begin
                        if (score_q != '1) score_q <= score_q + SCORE_W'(1);
                        if (apple_cnt == AW'(APPLES_PER_LEVEL - 1)) begin
                           apple_cnt <= '0;
                           if (level_q != 4'hF) level_q <= level_q + 4'd1;
                        end else apple_cnt <= apple_cnt + AW'(1);
                     end
                  end
               end else timer <= timer + PW'(1);
            end
            PAUSE: if (start_edge) state_q <= RUN;
            OVER: if (start_edge) begin
               state_q   <= IDLE;
               head_x    <= X_MID;
               head_y    <= Y_MID;
               dir_q     <= 2'b01;
               score_q   <= '0;
               level_q   <= '0;
               apple_cnt <= '0;
               timer     <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.step   = step;
   assign bus.grow   = step & bus.ate;
   assign bus.dir    = dir_q;
   assign bus.head_x = head_x;
   assign bus.head_y = head_y;
   assign bus.next_x = next_x;
   assign bus.next_y = next_y;
   assign bus.state  = state_q;
   assign bus.score  = score_q;
   assign bus.level  = level_q;
endmodule

// File: tb/tb_snake_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for snake_ctrl: one wrapping and one wall-killing instance
// share stimulus; predicted moves are queued and checked as each step appears.
module tb_snake_ctrl;
   logic clk = 1'b0;
   logic reset_n;
   logic btn_up, btn_dn, btn_lt, btn_rt, btn_start, self_hit, ate;

   always #5 clk = ~clk;

   snake_ctrl_if #(.X_BITS(6), .Y_BITS(5), .SCORE_W(8)) bus_w ();
   snake_ctrl_if #(.X_BITS(6), .Y_BITS(5), .SCORE_W(8)) bus_k ();

   assign bus_w.btn_up = btn_up;    assign bus_k.btn_up = btn_up;
   assign bus_w.btn_dn = btn_dn;    assign bus_k.btn_dn = btn_dn;
   assign bus_w.btn_lt = btn_lt;    assign bus_k.btn_lt = btn_lt;
   assign bus_w.btn_rt = btn_rt;    assign bus_k.btn_rt = btn_rt;
   assign bus_w.btn_start = btn_start; assign bus_k.btn_start = btn_start;
   assign bus_w.self_hit = self_hit; assign bus_k.self_hit = self_hit;
   assign bus_w.ate = ate;          assign bus_k.ate = ate;

   snake_ctrl #(.BASE_PERIOD(10), .MIN_PERIOD(4), .PERIOD_STEP(2), .APPLES_PER_LEVEL(2),
                .TURN_DEPTH(2), .WRAP(1)) dut_w (.clk(clk), .reset_n(reset_n), .bus(bus_w.master));
   snake_ctrl #(.BASE_PERIOD(10), .MIN_PERIOD(4), .PERIOD_STEP(2), .APPLES_PER_LEVEL(2),
                .TURN_DEPTH(2), .WRAP(0)) dut_k (.clk(clk), .reset_n(reset_n), .bus(bus_k.master));

   typedef struct {
      int hx; int hy; int d; int sc; int lv; int iv; int gr;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_step = 0;
   int   k_steps = 0;
   bit   chk_pend = 1'b0;

   localparam logic [4:0] B_UP = 5'b10000, B_DN = 5'b01000, B_LT = 5'b00100, B_START = 5'b00001;

   task automatic checkOutput(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
      end
   endtask

   function automatic exp_t mk(input int hx, input int hy, input int d, input int sc,
                               input int lv, input int iv, input int gr);
      exp_t e;
      e.hx = hx; e.hy = hy; e.d = d; e.sc = sc; e.lv = lv; e.iv = iv; e.gr = gr;
      return e;
   endfunction

   // Pops a prediction on every step and checks the registered result one cycle later.
   always @(negedge clk) begin
      cyc++;
      if (chk_pend) begin
         chk_pend = 1'b0;
         checkOutput("head_x", int'(bus_w.head_x), cur.hx);
         checkOutput("head_y", int'(bus_w.head_y), cur.hy);
         checkOutput("dir",    int'(bus_w.dir),    cur.d);
         checkOutput("score",  int'(bus_w.score),  cur.sc);
         checkOutput("level",  int'(bus_w.level),  cur.lv);
      end
      if (bus_w.step) begin
         checkOutput("step_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            checkOutput("grow", int'(bus_w.grow), cur.gr);
            if (cur.iv != 0) checkOutput("step_interval", cyc - last_step, cur.iv);
            chk_pend = 1'b1;
         end
         last_step = cyc;
      end
      if (bus_k.step) k_steps++;
   end

   task automatic applyStimulus(input logic [4:0] mask);
      {btn_up, btn_dn, btn_lt, btn_rt, btn_start} = mask;
      @(negedge clk);
      {btn_up, btn_dn, btn_lt, btn_rt, btn_start} = 5'b00000;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      {btn_up, btn_dn, btn_lt, btn_rt, btn_start} = 5'b00000;
      ate = 1'b0;
      self_hit = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_state",  int'(bus_w.state),  0);
      checkOutput("rst_head_x", int'(bus_w.head_x), 20);
      checkOutput("rst_head_y", int'(bus_w.head_y), 15);
      checkOutput("rst_dir",    int'(bus_w.dir),    1);
      checkOutput("rst_score",  int'(bus_w.score),  0);
      checkOutput("rst_level",  int'(bus_w.level),  0);
      checkOutput("rst_step",   int'(bus_w.step),   0);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic wait_state(input int want, input int budget);
      int n = 0;
      while (int'(bus_w.state) != want && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("state_reach", int'(bus_w.state), want);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      // Straight run to the right edge: wrap on one instance, death on the other.
      do_reset();
      applyStimulus(B_START);
      for (int i = 1; i <= 19; i++) exp_q.push_back(mk(20 + i, 15, 1, 0, 0, (i == 1) ? 0 : 10, 0));
      exp_q.push_back(mk(0, 15, 1, 0, 0, 10, 0));
`ifndef SNAKE_CTRL_PAUSE_EN
      n = 0;
      while (exp_q.size() > 16 && n < 200) begin @(negedge clk); n++; end
      applyStimulus(B_START);
      repeat (3) @(negedge clk);
      checkOutput("start_ignored_in_run", int'(bus_w.state), 1);
`endif
      wait_drain(400);
      checkOutput("wall_steps",  k_steps, 19);
      checkOutput("wall_head_x", int'(bus_k.head_x), 39);
      checkOutput("wall_state",  int'(bus_k.state), 3);
      checkOutput("wrap_state",  int'(bus_w.state), 1);

      // Turn in RUN: reversal rejected, up accepted.
      do_reset();
      applyStimulus(B_START);
      exp_q.push_back(mk(21, 15, 1, 0, 0, 0, 0));
      wait_drain(100);
      exp_q.push_back(mk(21, 14, 0, 0, 0, 10, 0));
      exp_q.push_back(mk(21, 13, 0, 0, 0, 10, 0));
      applyStimulus(B_LT);
      applyStimulus(B_UP);
      wait_drain(100);

      // Queue depth 2 filled in IDLE: third turn dropped.
      do_reset();
      applyStimulus(B_UP);
      applyStimulus(B_LT);
      applyStimulus(B_DN);
      repeat (3) @(negedge clk);
      checkOutput("idle_state", int'(bus_w.state), 0);
      checkOutput("idle_dir",   int'(bus_w.dir),   1);
      applyStimulus(B_START);
      exp_q.push_back(mk(20, 14, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(19, 14, 3, 0, 0, 10, 0));
      exp_q.push_back(mk(18, 14, 3, 0, 0, 10, 0));
      wait_drain(100);

      // Apples on six consecutive moves: score, level and speed-up.
      do_reset();
      ate = 1'b1;
      applyStimulus(B_START);
      exp_q.push_back(mk(21, 15, 1, 1, 0, 0, 1));
      exp_q.push_back(mk(22, 15, 1, 2, 1, 10, 1));
      exp_q.push_back(mk(23, 15, 1, 3, 1, 8, 1));
      exp_q.push_back(mk(24, 15, 1, 4, 2, 8, 1));
      exp_q.push_back(mk(25, 15, 1, 5, 2, 6, 1));
      exp_q.push_back(mk(26, 15, 1, 6, 3, 6, 1));
      exp_q.push_back(mk(27, 15, 1, 6, 3, 4, 0));
      n = 0;
      while (exp_q.size() > 1 && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
      ate = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      checkOutput("drain_apples", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);

      // Self collision ends the game; start returns to a fresh IDLE.
      self_hit = 1'b1;
      wait_state(3, 50);
      checkOutput("over_head_x", int'(bus_w.head_x), 27);
      checkOutput("over_head_y", int'(bus_w.head_y), 15);
      checkOutput("over_score",  int'(bus_w.score),  6);
      checkOutput("over_level",  int'(bus_w.level),  3);
      repeat (12) @(negedge clk);
      checkOutput("over_hold_x", int'(bus_w.head_x), 27);
      self_hit = 1'b0;
      applyStimulus(B_START);
      wait_state(0, 20);
      checkOutput("idle_score",  int'(bus_w.score),  0);
      checkOutput("idle_level",  int'(bus_w.level),  0);
      checkOutput("idle_head_x", int'(bus_w.head_x), 20);
      checkOutput("idle_dir2",   int'(bus_w.dir),    1);

`ifdef SNAKE_CTRL_PAUSE_EN
      // Pause freezes the game until a second start edge.
      applyStimulus(B_START);
      exp_q.push_back(mk(21, 15, 1, 0, 0, 0, 0));
      wait_drain(100);
      applyStimulus(B_START);
      wait_state(2, 10);
      repeat (30) @(negedge clk);
      checkOutput("pause_state",  int'(bus_w.state),  2);
      checkOutput("pause_head_x", int'(bus_w.head_x), 21);
      exp_q.push_back(mk(22, 15, 1, 0, 0, 0, 0));
      applyStimulus(B_START);
      wait_state(1, 10);
      wait_drain(100);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
